// File: rtl/sm_regdump_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_regdump_pkg                                                  |
// | Brief    : Shared state encoding and frame constants for the register dump |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package sm_regdump_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_SETADDR = 3'd2,
        S_CAPT    = 3'd3,
        S_SEND    = 3'd4,
        S_NEXT    = 3'd5,
        S_CRC     = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    localparam int c_BYTES_PER_REG = 5;
    localparam int c_UART_BITS     = 10;

endpackage
`default_nettype wire

// File: rtl/sm_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_uart_tx                                                      |
// | Brief    : 8N1 transmitter; ready also covers the final stop-bit cycle so  |
// |            consecutive bytes go out with no idle gap                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sm_uart_tx
    import sm_regdump_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int                    c_BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST = c_BAUD_W'(CLK_DIV - 1);
    localparam logic [c_BAUD_W-1:0]   c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [3:0]            c_BIT_LAST  = 4'(c_UART_BITS - 1);

    logic                r_active;
    logic [c_BAUD_W-1:0] r_baud;
    logic [3:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                w_bitEnd;

    assign w_bitEnd = (r_baud == c_BAUD_LAST);
    assign ready    = !r_active || (w_bitEnd && (r_bit == c_BIT_LAST));
    assign tx       = r_tx;

    // Bit 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else if (load && ready) begin
            r_active <= 1'b1;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= data;
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (w_bitEnd) begin
                r_baud <= '0;
                if (r_bit == c_BIT_LAST) begin
                    r_active <= 1'b0;
                    r_bit    <= '0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    if (r_bit == c_BIT_LAST - 4'd1) begin
                        r_tx <= 1'b1;
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                end
            end else begin
                r_baud <= r_baud + c_BAUD_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm_regdump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_regdump                                                      |
// | Brief    : Walks the CPU debug read port and streams a register snapshot   |
// |            over UART. Define SM_REGDUMP_CRC_EN for a trailing XOR byte.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int         NREG      = 32,
    parameter int         CLK_DIV   = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam logic [4:0] c_LAST_IDX  = 5'(NREG - 1);
    localparam logic [2:0] c_LAST_BYTE = 3'(c_BYTES_PER_REG - 1);

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [31:0] r_shadow;
    logic [2:0]  r_byteCnt;
    logic        r_busy;
    logic        r_done;
    logic [4:0]  r_regAddr;
`ifdef SM_REGDUMP_CRC_EN
    logic [7:0]  r_crc;
`endif

    logic        w_load;
    logic        w_ready;
    logic [7:0]  w_byte;

    assign regAddr = r_regAddr;
    assign busy    = r_busy;
    assign done    = r_done;

    // The header is loaded on the accepting edge so its start bit coincides
    // with the first busy cycle.
    always_comb begin
        w_load = 1'b0;
        w_byte = SYNC_BYTE;
        case (r_state)
            S_IDLE: begin
                w_load = start;
            end
            S_SEND: begin
                w_load = w_ready;
                case (r_byteCnt)
                    3'd0:    w_byte = {3'b000, r_idx};
                    3'd1:    w_byte = r_shadow[31:24];
                    3'd2:    w_byte = r_shadow[23:16];
                    3'd3:    w_byte = r_shadow[15:8];
                    default: w_byte = r_shadow[7:0];
                endcase
            end
`ifdef SM_REGDUMP_CRC_EN
            S_CRC: begin
                w_load = w_ready;
                w_byte = r_crc;
            end
`endif
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_shadow  <= '0;
            r_byteCnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_regAddr <= '0;
`ifdef SM_REGDUMP_CRC_EN
            r_crc     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef SM_REGDUMP_CRC_EN
            if (w_load) begin
                r_crc <= (r_state == S_IDLE) ? SYNC_BYTE : (r_crc ^ w_byte);
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_HDR;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                S_HDR: begin
                    r_regAddr <= r_idx;
                    r_state   <= S_SETADDR;
                end
                S_SETADDR: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_shadow  <= regData;
                    r_byteCnt <= '0;
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    if (w_ready) begin
                        if (r_byteCnt == c_LAST_BYTE) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_byteCnt <= r_byteCnt + 3'd1;
                        end
                    end
                end
                S_NEXT: begin
                    if (r_idx == c_LAST_IDX) begin
`ifdef SM_REGDUMP_CRC_EN
                        r_state <= S_CRC;
`else
                        r_state <= S_FIN;
`endif
                    end else begin
                        r_idx     <= r_idx + 5'd1;
                        r_regAddr <= r_idx + 5'd1;
                        r_state   <= S_SETADDR;
                    end
                end
`ifdef SM_REGDUMP_CRC_EN
                S_CRC: begin
                    if (w_ready) begin
                        r_state <= S_FIN;
                    end
                end
`endif
                S_FIN: begin
                    // ready here marks the last cycle of the final stop bit
                    if (w_ready) begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_regAddr <= '0;
                        r_idx     <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    sm_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .data  (w_byte),
        .ready (w_ready),
        .tx    (tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_sm_regdump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sm_regdump                                                   |
// | Brief    : Self-checking bench decoding the UART line of two sm_regdump    |
// |            instances against a frame model                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sm_regdump;

    localparam int c_NREG_A = 2;
    localparam int c_DIV_A  = 4;
    localparam int c_NREG_B = 32;
    localparam int c_DIV_B  = 16;
    localparam int c_NVEC   = 6;
`ifdef SM_REGDUMP_CRC_EN
    localparam int c_CRC_BYTES = 1;
`else
    localparam int c_CRC_BYTES = 0;
`endif

    typedef struct packed {
        logic [31:0] r0;
        logic [31:0] r1;
        logic [87:0] body;
        logic [7:0]  crc;
    } vec_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        startA = 1'b0;
    logic        startB = 1'b0;
    logic [4:0]  regAddrA, regAddrB;
    logic [31:0] regDataA, regDataB;
    logic        busyA, busyB, doneA, doneB, txA, txB;
    logic [31:0] regsA [32];
    logic [31:0] regsB [32];
    logic [31:0] modelRegs [32];
    int          cyc = 0;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [7:0]  expQ[$];
    logic [7:0]  gotQ[$];
    bit          waveQ[$];
    bit          samp[$];
    longint      riseCyc;
    longint      firstAddr1;
    vec_t        vecs [c_NVEC];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign regDataA = regsA[regAddrA];
    assign regDataB = (regAddrB == 5'd0) ? 32'(cyc) : regsB[regAddrB];

    sm_regdump #(.NREG(c_NREG_A), .CLK_DIV(c_DIV_A), .SYNC_BYTE(8'hA5)) u_dutA (
        .clk(clk), .rst(rst), .start(startA), .regAddr(regAddrA), .regData(regDataA),
        .busy(busyA), .done(doneA), .tx(txA)
    );

    sm_regdump #(.NREG(c_NREG_B), .CLK_DIV(c_DIV_B), .SYNC_BYTE(8'hA5)) u_dutB (
        .clk(clk), .rst(rst), .start(startB), .regAddr(regAddrB), .regData(regDataB),
        .busy(busyB), .done(doneB), .tx(txB)
    );

    function automatic logic getTx(input int inst);
        return (inst == 0) ? txA : txB;
    endfunction
    function automatic logic getBusy(input int inst);
        return (inst == 0) ? busyA : busyB;
    endfunction
    function automatic logic getDone(input int inst);
        return (inst == 0) ? doneA : doneB;
    endfunction
    function automatic logic [4:0] getAddr(input int inst);
        return (inst == 0) ? regAddrA : regAddrB;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setStart(input int inst, input logic v);
        if (inst == 0) startA = v;
        else           startB = v;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Frame model: header, then per register its index and big-endian value,
    // then optionally the XOR of everything already sent.
    task automatic build_expected(input int nreg);
        logic [7:0] x;
        expQ.delete();
        expQ.push_back(8'hA5);
        for (int i = 0; i < nreg; i++) begin
            expQ.push_back(8'(i));
            for (int b = 3; b >= 0; b--) expQ.push_back(modelRegs[i][8*b +: 8]);
        end
        if (c_CRC_BYTES != 0) begin
            x = 8'h00;
            foreach (expQ[k]) x ^= expQ[k];
            expQ.push_back(x);
        end
    endtask

    // Entered in the first busy cycle; samples tx for the whole frame, then
    // checks the done cycle and decodes bytes at exact bit positions.
    task automatic capture(input int inst, input int nbytes, input int cdiv,
                           input int midStart, input bit startAtDone, input string tag);
        int n;
        int earlyDone;
        int busyLow;
        n          = nbytes * 10 * cdiv;
        earlyDone  = 0;
        busyLow    = 0;
        firstAddr1 = -1;
        riseCyc    = cyc;
        samp.delete();
        check({tag, " busy rise"}, 64'(getBusy(inst)), 64'd1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            samp.push_back(getTx(inst));
            if (getDone(inst)) earlyDone++;
            if (!getBusy(inst)) busyLow++;
            if (firstAddr1 < 0 && getAddr(inst) == 5'd1) firstAddr1 = cyc;
            setStart(inst, (i == midStart));
        end
        tick();
        check({tag, " done early"}, 64'(earlyDone), 64'd0);
        check({tag, " busy dropped"}, 64'(busyLow), 64'd0);
        check({tag, " done at end"}, 64'(getDone(inst)), 64'd1);
        check({tag, " busy at end"}, 64'(getBusy(inst)), 64'd0);
        check({tag, " regAddr at end"}, 64'(getAddr(inst)), 64'd0);
        setStart(inst, startAtDone);
        gotQ.delete();
        waveQ.delete();
        for (int k = 0; k < nbytes; k++) begin
            bit       ok;
            bit       b;
            logic [7:0] val;
            int       base;
            ok   = 1'b1;
            val  = 8'h00;
            base = k * 10 * cdiv;
            for (int j = 0; j < 10; j++) begin
                b = samp[base + j*cdiv];
                for (int s = 1; s < cdiv; s++) if (samp[base + j*cdiv + s] != b) ok = 1'b0;
                if (j == 0 && b != 1'b0) ok = 1'b0;
                if (j == 9 && b != 1'b1) ok = 1'b0;
                if (j >= 1 && j <= 8) val[j-1] = b;
            end
            gotQ.push_back(val);
            waveQ.push_back(ok);
        end
    endtask

    task automatic compare_frame(input string tag);
        for (int k = 0; k < expQ.size(); k++)
            check($sformatf("%s byte%0d {waveOk,value}", tag, k), {55'd0, waveQ[k], gotQ[k]},
                  {55'd0, 1'b1, expQ[k]});
    endtask

    task automatic load_vec(input int v);
        regsA[0] = vecs[v].r0;
        regsA[1] = vecs[v].r1;
        expQ.delete();
        for (int k = 0; k < 11; k++) expQ.push_back(vecs[v].body[87 - 8*k -: 8]);
        if (c_CRC_BYTES != 0) expQ.push_back(vecs[v].crc);
    endtask

    initial begin
        logic [31:0] pcGot;
        logic [7:0]  x;
        for (int i = 0; i < 32; i++) begin
            regsA[i] = 32'h0;
            regsB[i] = $urandom;
        end

        vecs[0] = '{r0: 32'h00000005, r1: 32'h12345678,
                    body: 88'hA5_00_00000005_01_12345678, crc: 8'hA9};
        vecs[1] = '{r0: 32'h00000000, r1: 32'hFFFFFFFF,
                    body: 88'hA5_00_00000000_01_FFFFFFFF, crc: 8'hA4};
        vecs[2] = '{r0: 32'h80000001, r1: 32'hA5A5A5A5,
                    body: 88'hA5_00_80000001_01_A5A5A5A5, crc: 8'h25};
        for (int v = 3; v < c_NVEC; v++) begin
            vecs[v].r0   = $urandom;
            vecs[v].r1   = $urandom;
            modelRegs[0] = vecs[v].r0;
            modelRegs[1] = vecs[v].r1;
            build_expected(2);
            vecs[v].body = '0;
            x = 8'h00;
            for (int k = 0; k < 11; k++) begin
                vecs[v].body = {vecs[v].body[79:0], expQ[k]};
                x ^= expQ[k];
            end
            vecs[v].crc = x;
        end

        repeat (3) tick();
        check("reset regAddrA", 64'(regAddrA), 64'd0);
        check("reset busyA", 64'(busyA), 64'd0);
        check("reset doneA", 64'(doneA), 64'd0);
        check("reset txA", 64'(txA), 64'd1);
        check("reset busyB", 64'(busyB), 64'd0);
        check("reset txB", 64'(txB), 64'd1);
        rst = 1'b0;
        repeat (2) tick();
        check("idle txA", 64'(txA), 64'd1);

        // Back-to-back frames: each new start lands in the done cycle.
        for (int v = 0; v < c_NVEC; v++) begin
            load_vec(v);
            setStart(0, 1'b1);
            tick();
            setStart(0, 1'b0);
            capture(0, expQ.size(), c_DIV_A, (v == 0) ? 150 : -1, (v < c_NVEC - 1),
                    $sformatf("vec%0d", v));
            compare_frame($sformatf("vec%0d", v));
        end
        tick();
        check("idle after frames busyA", 64'(busyA), 64'd0);
        check("idle after frames txA", 64'(txA), 64'd1);

        // Reset in the middle of the third byte.
        load_vec(0);
        setStart(0, 1'b1);
        tick();
        setStart(0, 1'b0);
        repeat (94) tick();
        check("busy before mid reset", 64'(busyA), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset txA", 64'(txA), 64'd1);
        check("mid reset busyA", 64'(busyA), 64'd0);
        check("mid reset regAddrA", 64'(regAddrA), 64'd0);
        check("mid reset doneA", 64'(doneA), 64'd0);
        repeat (3) tick();
        check("after reset txA idle", 64'(txA), 64'd1);

        rst = 1'b1;
        setStart(0, 1'b1);
        tick();
        rst = 1'b0;
        setStart(0, 1'b0);
        tick();
        check("reset beats start busyA", 64'(busyA), 64'd0);
        check("reset beats start txA", 64'(txA), 64'd1);

        load_vec(2);
        setStart(0, 1'b1);
        tick();
        setStart(0, 1'b0);
        capture(0, expQ.size(), c_DIV_A, -1, 1'b0, "post reset");
        compare_frame("post reset");

        // Full 32-register dump with a running PC at address 0.
        setStart(1, 1'b1);
        tick();
        setStart(1, 1'b0);
        capture(1, 1 + 5*c_NREG_B + c_CRC_BYTES, c_DIV_B, -1, 1'b0, "nreg32");
        pcGot = {gotQ[2], gotQ[3], gotQ[4], gotQ[5]};
        check("nreg32 pc within reg0 window",
              64'((longint'(pcGot) >= riseCyc) && (longint'(pcGot) < firstAddr1)), 64'd1);
        modelRegs[0] = pcGot;
        for (int i = 1; i < 32; i++) modelRegs[i] = regsB[i];
        build_expected(c_NREG_B);
        compare_frame("nreg32");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
